// File: rtl/psk_frame_modulator.sv
// Framed BPSK/QPSK modulator between the carrier datapath and the DAC driver.
// A fixed BPSK preamble precedes the payload; optional additive noise is saturated to the sample range.
module psk_frame_modulator #(
  parameter int SAMPLE_W = 16,
  parameter int SPS = 16,
  parameter int PREAMBLE_LEN = 8,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_PAT = 8'b10101100
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic                mode,
  input  logic [15:0]         frame_len,
  input  logic                bit_valid,
  input  logic                bit_data,
  output logic                bit_ready,
  input  logic                car_valid,
  input  logic [SAMPLE_W-1:0] car_i,
  input  logic [SAMPLE_W-1:0] car_q,
  input  logic                noise_en,
  input  logic [SAMPLE_W-1:0] noise,
  input  logic                dac_busy,
  output logic                dac_dav,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output logic                overrun
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [PREAMBLE_LEN-1:0] PRE_MSB = PREAMBLE_LEN'(1) << (PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_FLUSH} state_t;

  state_t              state;
  logic                mode_r;
  logic [15:0]         len_r;
  logic [15:0]         sym_cnt;
  logic [CNT_W-1:0]    samp_cnt;
  logic                sym_b1, sym_b0, sym_zero, sym_qpsk;
  logic [1:0]          buf_bits;
  logic [1:0]          buf_cnt;

  logic                active, latch, have_bits, bit_accept, pop_one, pop_two;
  logic                cur_b1, cur_b0, cur_zero, cur_qpsk;
  logic [1:0]          buf_next, cnt_next;
  logic [SAMPLE_W-1:0] term_i, term_q, sym_sample, out_sample;
  logic signed [SAMPLE_W:0] pair_sum, noisy;

  function automatic logic [SAMPLE_W-1:0] neg_sat(input logic [SAMPLE_W-1:0] x);
    return (x == S_MIN) ? S_MAX : -x;
  endfunction

  assign active     = (state == S_PREAMBLE) || (state == S_PAYLOAD);
  assign busy       = (state != S_IDLE);
  assign bit_ready  = active && (buf_cnt != 2'd2);
  assign bit_accept = bit_valid && bit_ready;
  assign latch      = active && car_valid && (samp_cnt == '0);
  assign have_bits  = mode_r ? (buf_cnt == 2'd2) : (buf_cnt != 2'd0);
  assign pop_one    = latch && (state == S_PAYLOAD) && have_bits && !mode_r;
  assign pop_two    = latch && (state == S_PAYLOAD) && have_bits && mode_r;

  // A symbol applies from the sample that latches it, so the first sample uses the fresh bits.
  always_comb begin
    cur_b1   = sym_b1;
    cur_b0   = sym_b0;
    cur_zero = sym_zero;
    cur_qpsk = sym_qpsk;
    if (latch) begin
      if (state == S_PREAMBLE) begin
        cur_b1   = |(PREAMBLE_PAT & (PRE_MSB >> sym_cnt));
        cur_b0   = 1'b0;
        cur_zero = 1'b0;
        cur_qpsk = 1'b0;
      end else begin
        cur_b1   = buf_bits[0];
        cur_b0   = mode_r ? buf_bits[1] : 1'b0;
        cur_zero = !have_bits;
        cur_qpsk = mode_r;
      end
    end
  end

  always_comb begin
    term_i   = cur_b1 ? car_i : neg_sat(car_i);
    term_q   = cur_b0 ? car_q : neg_sat(car_q);
    pair_sum = $signed({term_i[SAMPLE_W-1], term_i}) + $signed({term_q[SAMPLE_W-1], term_q});
    if (cur_zero)
      sym_sample = '0;
    else if (cur_qpsk)
      sym_sample = SAMPLE_W'(pair_sum >>> 1);
    else
      sym_sample = term_i;
    noisy = $signed({sym_sample[SAMPLE_W-1], sym_sample}) + $signed({noise[SAMPLE_W-1], noise});
    if (!noise_en)
      out_sample = sym_sample;
    else if (noisy[SAMPLE_W] != noisy[SAMPLE_W-1])
      out_sample = noisy[SAMPLE_W] ? S_MIN : S_MAX;
    else
      out_sample = noisy[SAMPLE_W-1:0];
  end

  // Pops happen before the push, so a bit arriving with a latch is never consumed by it.
  always_comb begin
    buf_next = buf_bits;
    cnt_next = buf_cnt;
    if (state == S_IDLE) begin
      buf_next = '0;
      cnt_next = '0;
    end else begin
      if (pop_one) begin
        buf_next = {1'b0, buf_bits[1]};
        cnt_next = buf_cnt - 2'd1;
      end else if (pop_two) begin
        buf_next = '0;
        cnt_next = '0;
      end
      if (bit_accept) begin
        buf_next[cnt_next[0]] = bit_data;
        cnt_next = cnt_next + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      mode_r     <= 1'b0;
      len_r      <= '0;
      sym_cnt    <= '0;
      samp_cnt   <= '0;
      sym_b1     <= 1'b0;
      sym_b0     <= 1'b0;
      sym_zero   <= 1'b0;
      sym_qpsk   <= 1'b0;
      buf_bits   <= '0;
      buf_cnt    <= '0;
      dac_dav    <= 1'b0;
      dac_data   <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dac_dav    <= 1'b0;
      frame_done <= 1'b0;
      buf_bits   <= buf_next;
      buf_cnt    <= cnt_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r   <= mode;
            len_r    <= frame_len;
            underrun <= 1'b0;
            overrun  <= 1'b0;
            samp_cnt <= '0;
            sym_cnt  <= '0;
            if (frame_len != 16'd0)
              state <= S_PREAMBLE;
            else
              frame_done <= 1'b1;
          end
        end
        S_PREAMBLE, S_PAYLOAD: begin
          if (car_valid) begin
            if (latch) begin
              sym_b1   <= cur_b1;
              sym_b0   <= cur_b0;
              sym_zero <= cur_zero;
              sym_qpsk <= cur_qpsk;
            end
            if (latch && (state == S_PAYLOAD) && !have_bits)
              underrun <= 1'b1;
            // A busy DAC loses this sample, but symbol timing keeps running.
            if (dac_busy) begin
              overrun <= 1'b1;
            end else begin
              dac_dav  <= 1'b1;
              dac_data <= out_sample;
            end
            if (samp_cnt == CNT_W'(SPS - 1)) begin
              samp_cnt <= '0;
              if ((state == S_PREAMBLE) && (sym_cnt == 16'(PREAMBLE_LEN - 1))) begin
                state   <= S_PAYLOAD;
                sym_cnt <= '0;
              end else if ((state == S_PAYLOAD) && (sym_cnt == len_r - 16'd1)) begin
                state   <= S_FLUSH;
                sym_cnt <= '0;
              end else begin
                sym_cnt <= sym_cnt + 16'd1;
              end
            end else begin
              samp_cnt <= samp_cnt + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (!dac_busy) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
